// File: rtl/reg_file_mp_if.sv
// Command/read bus for the multi-port register file.
// master drives CE/Op/addresses/data; slave returns OutA/OutB/Busy/Carry/Zero.
interface reg_file_mp_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);
  logic              CE;
  logic [2:0]        Op;
  logic [ADDR_W-1:0] WrAddr;
  logic [DATA_W-1:0] WrData;
  logic [ADDR_W-1:0] RdAddrA;
  logic [ADDR_W-1:0] RdAddrB;
  logic [DATA_W-1:0] OutA;
  logic [DATA_W-1:0] OutB;
  logic              Busy;
  logic              Carry;
  logic              Zero;

  modport master (
    output CE, Op, WrAddr, WrData, RdAddrA, RdAddrB,
    input  OutA, OutB, Busy, Carry, Zero
  );

  modport slave (
    input  CE, Op, WrAddr, WrData, RdAddrA, RdAddrB,
    output OutA, OutB, Busy, Carry, Zero
  );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 registered write-first read ports, 1 write port
// with WRITE/INC/DEC/SWAP. Ports: clk, Reset (sync, active-high), bus (slave).
module reg_file_mp #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
) (
  input logic          clk,
  input logic          Reset,
  reg_file_mp_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, SWAP2} state_t;

  state_t            state;
  state_t            state_n;
  logic [DATA_W-1:0] rf [DEPTH];
  logic [DATA_W-1:0] tmp;
  logic [ADDR_W-1:0] sw_addr;
  logic [DATA_W-1:0] out_a;
  logic [DATA_W-1:0] out_b;
  logic              carry;
  logic              zero;

  logic              go;
  logic              op_wr;
  logic              op_inc;
  logic              op_dec;
  logic              op_sw;
  logic              in_sw2;
  logic [DATA_W-1:0] old;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic              tmp_we;
  logic              fl_we;
  logic              c_n;
  logic              z_n;

  assign go     = (state == IDLE) && bus.CE;
  assign op_wr  = go && (bus.Op == 3'b001);
  assign op_inc = go && (bus.Op == 3'b010);
  assign op_dec = go && (bus.Op == 3'b011);
  assign op_sw  = go && (bus.Op == 3'b100);
  assign in_sw2 = (state == SWAP2);
  assign old    = rf[bus.WrAddr];

  always_ff @(posedge clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  if (op_sw) state_n = SWAP2;
      SWAP2: state_n = IDLE;
    endcase
  end

  always_comb begin
    we     = 1'b0;
    wa     = bus.WrAddr;
    wd     = bus.WrData;
    tmp_we = 1'b0;
    fl_we  = 1'b0;
    c_n    = carry;
    z_n    = zero;
    unique case (1'b1)
      op_wr: we = 1'b1;
      op_inc: begin
        we    = 1'b1;
        wd    = old + ONE;
        fl_we = 1'b1;
        c_n   = &old;
        z_n   = (wd == '0);
      end
      op_dec: begin
        we    = 1'b1;
        wd    = old - ONE;
        fl_we = 1'b1;
        c_n   = (old == '0);
        z_n   = (wd == '0);
      end
      op_sw: begin
        we     = 1'b1;
        wd     = rf[bus.RdAddrA];
        tmp_we = 1'b1;
      end
      in_sw2: begin
        we = 1'b1;
        wa = sw_addr;
        wd = tmp;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      tmp     <= '0;
      sw_addr <= '0;
      carry   <= 1'b0;
      zero    <= 1'b0;
      out_a   <= '0;
      out_b   <= '0;
    end else begin
      if (we) rf[wa] <= wd;
      if (tmp_we) begin
        tmp     <= old;
        sw_addr <= bus.RdAddrA;
      end
      if (fl_we) begin
        carry <= c_n;
        zero  <= z_n;
      end
      // write-first: forward the value landing on this edge
      out_a <= (we && wa == bus.RdAddrA) ? wd : rf[bus.RdAddrA];
      out_b <= (we && wa == bus.RdAddrB) ? wd : rf[bus.RdAddrB];
    end
  end

  assign bus.OutA  = out_a;
  assign bus.OutB  = out_b;
  assign bus.Busy  = in_sw2;
  assign bus.Carry = carry;
  assign bus.Zero  = zero;
endmodule

// File: tb/tb_reg_file_mp.sv
// Directed self-checking bench for reg_file_mp (8x4 and 16x8 instances).
// Stimulus is a linear list of steps; each check is an immediate assertion.
module tb_reg_file_mp;
  localparam logic [2:0] NOP = 3'b000;
  localparam logic [2:0] WR  = 3'b001;
  localparam logic [2:0] INC = 3'b010;
  localparam logic [2:0] DEC = 3'b011;
  localparam logic [2:0] SWP = 3'b100;
  localparam logic [2:0] RSV = 3'b111;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  reg_file_mp_if #(.DATA_W(8),  .ADDR_W(2)) a ();
  reg_file_mp_if #(.DATA_W(16), .ADDR_W(3)) b ();

  reg_file_mp #(.DATA_W(8), .ADDR_W(2)) dut_a (
    .clk   (clk),
    .Reset (rst),
    .bus   (a)
  );

  reg_file_mp #(.DATA_W(16), .ADDR_W(3)) dut_b (
    .clk   (clk),
    .Reset (rst),
    .bus   (b)
  );

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cyc(input logic ce, input logic [2:0] op,
                     input logic [1:0] wa, input logic [7:0] wd,
                     input logic [1:0] ra, input logic [1:0] rb);
    a.CE = ce; a.Op = op; a.WrAddr = wa; a.WrData = wd;
    a.RdAddrA = ra; a.RdAddrB = rb;
    @(posedge clk); #1;
  endtask

  task automatic cyc2(input logic ce, input logic [2:0] op,
                      input logic [2:0] wa, input logic [15:0] wd,
                      input logic [2:0] ra);
    b.CE = ce; b.Op = op; b.WrAddr = wa; b.WrData = wd;
    b.RdAddrA = ra; b.RdAddrB = 3'd0;
    @(posedge clk); #1;
  endtask

  initial begin
    b.CE = 0; b.Op = NOP; b.WrAddr = 0; b.WrData = 0;
    b.RdAddrA = 0; b.RdAddrB = 0;
    rst = 1;
    cyc(0, NOP, 0, 0, 0, 0);
    chk("rst_outa", 16'(a.OutA), 16'h0);
    chk("rst_outb", 16'(a.OutB), 16'h0);
    chk("rst_busy", 16'(a.Busy), 16'h0);
    chk("rst_carry", 16'(a.Carry), 16'h0);
    chk("rst_zero", 16'(a.Zero), 16'h0);
    rst = 0;

    cyc(1, WR, 1, 8'd4, 1, 0);
    chk("wr1_bypass", 16'(a.OutA), 16'd4);
    cyc(1, WR, 2, 8'd5, 2, 0);
    chk("wr2_bypass", 16'(a.OutA), 16'd5);
    cyc(1, WR, 3, 8'd6, 3, 0);
    chk("wr3_bypass", 16'(a.OutA), 16'd6);
    cyc(0, NOP, 0, 0, 1, 2);
    chk("rd_r1", 16'(a.OutA), 16'd4);
    chk("rd_r2", 16'(a.OutB), 16'd5);
    cyc(0, NOP, 0, 0, 3, 0);
    chk("rd_r3", 16'(a.OutA), 16'd6);
    chk("rd_r0", 16'(a.OutB), 16'd0);

    cyc(1, WR, 0, 8'hFF, 0, 0);
    chk("wr0_ff", 16'(a.OutA), 16'h00FF);
    cyc(1, INC, 0, 0, 0, 0);
    chk("inc_wrap", 16'(a.OutA), 16'h0);
    chk("inc_carry", 16'(a.Carry), 16'h1);
    chk("inc_zero", 16'(a.Zero), 16'h1);
    cyc(1, DEC, 0, 0, 0, 0);
    chk("dec_wrap", 16'(a.OutA), 16'h00FF);
    chk("dec_borrow", 16'(a.Carry), 16'h1);
    chk("dec_zero", 16'(a.Zero), 16'h0);
    cyc(1, INC, 0, 0, 0, 0);
    cyc(1, WR, 1, 8'd3, 1, 0);
    chk("wr_keep_val", 16'(a.OutA), 16'd3);
    chk("wr_keep_c", 16'(a.Carry), 16'h1);
    chk("wr_keep_z", 16'(a.Zero), 16'h1);
    cyc(1, INC, 1, 0, 1, 0);
    chk("inc_plain", 16'(a.OutA), 16'd4);
    chk("inc_plain_c", 16'(a.Carry), 16'h0);
    chk("inc_plain_z", 16'(a.Zero), 16'h0);
    cyc(1, DEC, 1, 0, 1, 0);
    chk("dec_plain", 16'(a.OutA), 16'd3);
    cyc(1, INC, 1, 0, 1, 0);

    // regs: r0=0 r1=4 r2=5 r3=6
    cyc(1, SWP, 1, 0, 2, 1);
    chk("swp1_busy", 16'(a.Busy), 16'h1);
    chk("swp1_outa", 16'(a.OutA), 16'd5);
    chk("swp1_outb", 16'(a.OutB), 16'd5);
    cyc(1, WR, 2, 8'd99, 2, 1);
    chk("swp2_busy", 16'(a.Busy), 16'h0);
    chk("swp2_bypass", 16'(a.OutA), 16'd4);
    chk("swp2_outb", 16'(a.OutB), 16'd5);
    cyc(0, NOP, 0, 0, 1, 2);
    chk("swp_r1", 16'(a.OutA), 16'd5);
    chk("swp_r2_drop", 16'(a.OutB), 16'd4);
    chk("swp_keep_c", 16'(a.Carry), 16'h0);

    cyc(1, SWP, 3, 0, 3, 0);
    chk("self1_busy", 16'(a.Busy), 16'h1);
    chk("self1_outa", 16'(a.OutA), 16'd6);
    cyc(0, NOP, 0, 0, 3, 0);
    chk("self2_busy", 16'(a.Busy), 16'h0);
    chk("self2_outa", 16'(a.OutA), 16'd6);

    cyc(0, WR, 0, 8'hAA, 0, 1);
    chk("ce0_r0", 16'(a.OutA), 16'd0);
    chk("ce0_r1", 16'(a.OutB), 16'd5);
    cyc(1, RSV, 0, 8'hAA, 0, 2);
    chk("rsv_r0", 16'(a.OutA), 16'd0);
    chk("rsv_r2", 16'(a.OutB), 16'd4);
    cyc(1, NOP, 0, 8'hAA, 0, 0);
    chk("nop_r0", 16'(a.OutA), 16'd0);

    cyc(1, SWP, 1, 0, 2, 3);
    chk("abort_busy1", 16'(a.Busy), 16'h1);
    rst = 1;
    cyc(0, NOP, 0, 0, 1, 2);
    chk("abort_busy0", 16'(a.Busy), 16'h0);
    chk("abort_outa", 16'(a.OutA), 16'h0);
    rst = 0;
    cyc(0, NOP, 0, 0, 1, 2);
    chk("abort_r1", 16'(a.OutA), 16'h0);
    chk("abort_r2", 16'(a.OutB), 16'h0);
    cyc(0, NOP, 0, 0, 0, 3);
    chk("abort_r0", 16'(a.OutA), 16'h0);
    chk("abort_r3", 16'(a.OutB), 16'h0);

    cyc2(1, WR, 3'd5, 16'hFFFF, 3'd5);
    chk("w16_ffff", b.OutA, 16'hFFFF);
    cyc2(1, WR, 3'd7, 16'h1234, 3'd7);
    chk("w16_r7", b.OutA, 16'h1234);
    cyc2(1, INC, 3'd5, 16'h0, 3'd5);
    chk("w16_inc", b.OutA, 16'h0);
    chk("w16_carry", 16'(b.Carry), 16'h1);
    chk("w16_zero", 16'(b.Zero), 16'h1);
    cyc2(0, NOP, 3'd0, 16'h0, 3'd7);
    chk("w16_r7_keep", b.OutA, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
